hdmi_tx_config_sequencer: RTL and testbench

// Sequences the HDMI transmitter (ADV7513) register setup by issuing a fixed table of
// I2C byte-writes to a separate I2C write master through a valid/ready/done handshake.

---
 rtl/hdmi_tx_config_sequencer_if.sv | 21 ++
 rtl/hdmi_tx_config_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_hdmi_tx_config_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_tx_config_sequencer_if.sv
// Command channel between the HDMI config sequencer and its I2C write master.
// The master modport is the sequencer side; slave is the I2C engine side.
interface hdmi_tx_config_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       cmd_done;
  logic       cmd_nack;

  modport master (
    output cmd_valid, cmd_dev, cmd_reg, cmd_data,
    input  cmd_ready, cmd_done, cmd_nack
  );

  modport slave (
    input  cmd_valid, cmd_dev, cmd_reg, cmd_data,
    output cmd_ready, cmd_done, cmd_nack
  );
endinterface

// File: rtl/hdmi_tx_config_sequencer.sv
// Walks the ADV7513 register table as I2C byte-writes, retrying NACKs and
// replaying the whole table on every hot-plug edge.
module hdmi_tx_config_sequencer #(
  parameter int unsigned POWERUP_CYCLES = 500000,
  parameter int unsigned RETRY_GAP      = 50000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter logic [6:0]  DEV_ADDR       = 7'h39
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              hpd_event,
  hdmi_tx_config_sequencer_if.master        cmd,
  output logic                              busy,
  output logic                              cfg_done,
  output logic                              cfg_error
);

  localparam int unsigned TIMER_MAX   = (POWERUP_CYCLES > RETRY_GAP) ? POWERUP_CYCLES : RETRY_GAP;
  localparam int unsigned TW          = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam int unsigned RW          = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int unsigned IW          = 4;
  localparam int unsigned NUM_ENTRIES = 12;

  typedef enum logic [2:0] {
    S_WAIT_PWR, S_ISSUE, S_WAIT_ACK, S_RETRY_WAIT, S_DONE, S_ERROR
  } state_t;

  // {register, data} pairs in write order
  function automatic logic [15:0] table_entry(input logic [IW-1:0] i);
    case (i)
      4'd0:    return 16'h4110;
      4'd1:    return 16'h9803;
      4'd2:    return 16'h9AE0;
      4'd3:    return 16'h9C30;
      4'd4:    return 16'h9D61;
      4'd5:    return 16'hA2A4;
      4'd6:    return 16'hA3A4;
      4'd7:    return 16'hE0D0;
      4'd8:    return 16'hF900;
      4'd9:    return 16'h1500;
      4'd10:   return 16'h1630;
      4'd11:   return 16'hAF04;
      default: return 16'h0000;
    endcase
  endfunction

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [IW-1:0] index, index_n;
  logic [RW-1:0] retries, retries_n;
  logic          pending, pending_n;
  logic          restart;
  logic          hpd_s1, hpd_s2, hpd_s3;
  logic          hpd_rise;
  logic          valid_q, valid_n;
  logic [7:0]    reg_q, reg_n, data_q, data_n;
  logic          busy_n, cfg_done_n, cfg_error_n;
  logic [15:0]   entry_n;

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_reg   = reg_q;
  assign cmd.cmd_data  = data_q;
  assign cmd.cmd_dev   = DEV_ADDR;

  // Two-flop synchroniser plus edge detect for the hot-plug line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpd_s1 <= 1'b0;
      hpd_s2 <= 1'b0;
      hpd_s3 <= 1'b0;
    end else begin
      hpd_s1 <= hpd_event;
      hpd_s2 <= hpd_s1;
      hpd_s3 <= hpd_s2;
    end
  end

  assign hpd_rise = hpd_s2 & ~hpd_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_WAIT_PWR;
      timer     <= '0;
      index     <= '0;
      retries   <= '0;
      pending   <= 1'b0;
      valid_q   <= 1'b0;
      reg_q     <= '0;
      data_q    <= '0;
      busy      <= 1'b1;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      index     <= index_n;
      retries   <= retries_n;
      pending   <= pending_n;
      valid_q   <= valid_n;
      reg_q     <= reg_n;
      data_q    <= data_n;
      busy      <= busy_n;
      cfg_done  <= cfg_done_n;
      cfg_error <= cfg_error_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    index_n   = index;
    retries_n = retries;
    pending_n = pending;
    restart   = 1'b0;

    case (state)
      S_WAIT_PWR: begin
        if (hpd_rise) begin
          restart = 1'b1;
        end else if (timer == TW'(POWERUP_CYCLES - 1)) begin
          state_n = S_ISSUE;
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      // An accept in the same cycle as a hot-plug edge still goes out; restart follows its DONE
      S_ISSUE: begin
        if (valid_q && cmd.cmd_ready) begin
          state_n   = S_WAIT_ACK;
          pending_n = hpd_rise;
        end else if (hpd_rise) begin
          restart = 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (cmd.cmd_done) begin
          if (pending || hpd_rise) begin
            restart = 1'b1;
          end else if (!cmd.cmd_nack) begin
            if (index == IW'(NUM_ENTRIES - 1)) begin
              state_n = S_DONE;
            end else begin
              index_n   = index + IW'(1);
              retries_n = '0;
              state_n   = S_ISSUE;
            end
          end else if (retries == RW'(MAX_RETRIES)) begin
            state_n = S_ERROR;
          end else begin
            retries_n = retries + RW'(1);
            timer_n   = '0;
            state_n   = S_RETRY_WAIT;
          end
        end else if (hpd_rise) begin
          pending_n = 1'b1;
        end
      end
      S_RETRY_WAIT: begin
        if (hpd_rise) begin
          restart = 1'b1;
        end else if (timer == TW'(RETRY_GAP - 1)) begin
          state_n = S_ISSUE;
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      S_DONE, S_ERROR: begin
        if (hpd_rise) restart = 1'b1;
      end
      default: state_n = S_WAIT_PWR;
    endcase

    if (restart) begin
      state_n   = S_WAIT_PWR;
      timer_n   = '0;
      index_n   = '0;
      retries_n = '0;
      pending_n = 1'b0;
    end

    // Registered outputs follow the state being entered
    entry_n     = table_entry(index_n);
    valid_n     = (state_n == S_ISSUE);
    reg_n       = valid_n ? entry_n[15:8] : reg_q;
    data_n      = valid_n ? entry_n[7:0]  : data_q;
    busy_n      = !((state_n == S_DONE) || (state_n == S_ERROR));
    cfg_done_n  = (state_n == S_DONE);
    cfg_error_n = (state_n == S_ERROR);
  end

endmodule

// File: tb/tb_hdmi_tx_config_sequencer.sv
// Bench for hdmi_tx_config_sequencer: I2C master BFM, transaction-level model
// checked every cycle, and directed scenarios with literal expectations.
module tb_hdmi_tx_config_sequencer;
  localparam int unsigned PWR  = 16;
  localparam int unsigned GAP  = 8;
  localparam int unsigned MAXR = 2;
  localparam int ST_RUN = 0, ST_DONE = 1, ST_ERR = 2;

  logic clk = 1'b0;
  logic rst;
  logic hpd_event;
  logic busy, cfg_done, cfg_error;

  hdmi_tx_config_sequencer_if bus();

  hdmi_tx_config_sequencer #(
    .POWERUP_CYCLES(PWR), .RETRY_GAP(GAP), .MAX_RETRIES(MAXR), .DEV_ADDR(7'h39)
  ) dut (
    .clk(clk), .rst(rst), .hpd_event(hpd_event), .cmd(bus),
    .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  always #10 clk = ~clk;

  logic [15:0] tbl [12] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
                            16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'hAF04};

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [7:0] r);
    for (int i = 0; i < 12; i++) if (tbl[i][15:8] == r) return i;
    return 0;
  endfunction

  // ---------------- I2C master BFM ----------------
  int  wait_left = -1;
  int  done_dly  = 0;
  bit  in_txn    = 0;
  int  cur_idx   = 0;
  int  nack_left [12];
  bit  nack_always [12];
  bit  bp_en = 0;
  int  fixed_dly = -1;
  int  done_lat = 2;
  bit  inject_done = 0;

  initial begin
    bus.cmd_ready = 1'b0;
    bus.cmd_done  = 1'b0;
    bus.cmd_nack  = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.cmd_done = 1'b0;
      bus.cmd_nack = 1'b0;
      if (rst) begin
        bus.cmd_ready = 1'b0; in_txn = 0; wait_left = -1;
      end else if (bus.cmd_ready) begin
        bus.cmd_ready = 1'b0; in_txn = 1; done_dly = done_lat; wait_left = -1;
      end else if (in_txn) begin
        if (done_dly == 0) begin
          bus.cmd_done = 1'b1;
          in_txn = 0;
          if (nack_always[cur_idx]) bus.cmd_nack = 1'b1;
          else if (nack_left[cur_idx] > 0) begin
            bus.cmd_nack = 1'b1;
            nack_left[cur_idx]--;
          end
        end else done_dly--;
      end else if (inject_done) begin
        bus.cmd_done = 1'b1;
        inject_done = 0;
      end else if (bus.cmd_valid) begin
        if (wait_left < 0) begin
          cur_idx = idx_of(bus.cmd_reg);
          if (bp_en && cur_idx == 3) wait_left = 5;
          else if (fixed_dly >= 0) wait_left = fixed_dly;
          else wait_left = int'($urandom_range(0, 3));
        end
        if (wait_left == 0) bus.cmd_ready = 1'b1;
        else wait_left--;
      end else wait_left = -1;
    end
  end

  // ---------------- transaction-level model + per-cycle compare ----------------
  logic [3:0]  h = '0;
  int          m_idx = 0, m_retries = 0, m_valid_at = 0, m_status = ST_RUN;
  bit          m_out = 0, m_pend = 0;
  logic [15:0] acc_log [$];
  int          hold_9c = 0, min_gap = 1000, n_gaps = 0, nack_cyc = -1;
  bit          prev_valid = 0, prev_hold = 0;
  logic [15:0] prev_rd = '0;

  task automatic m_restart();
    m_idx = 0; m_retries = 0; m_status = ST_RUN; m_out = 0; m_pend = 0;
    m_valid_at = cyc + 1 + int'(PWR);
    nack_cyc = -1;
  endtask

  always @(negedge clk) begin
    bit rise, acc, exp_valid;
    int gap;
    h = {h[2:0], hpd_event};
    rise = h[2] & ~h[3];
    if (rst) begin
      h = '0;
      m_restart();
      prev_valid = 0; prev_hold = 0;
      chk("rst_valid", 32'(bus.cmd_valid), 32'd0);
      chk("rst_reg",   32'(bus.cmd_reg),   32'd0);
      chk("rst_data",  32'(bus.cmd_data),  32'd0);
      chk("rst_busy",  32'(busy),          32'd1);
      chk("rst_done",  32'(cfg_done),      32'd0);
      chk("rst_error", 32'(cfg_error),     32'd0);
    end else begin
      exp_valid = (m_status == ST_RUN) && !m_out && (cyc >= m_valid_at);
      chk("valid",     32'(bus.cmd_valid), 32'(exp_valid));
      chk("busy",      32'(busy),          32'(m_status == ST_RUN));
      chk("cfg_done",  32'(cfg_done),      32'(m_status == ST_DONE));
      chk("cfg_error", 32'(cfg_error),     32'(m_status == ST_ERR));
      if (bus.cmd_valid) begin
        chk("cmd_dev",  32'(bus.cmd_dev), 32'h39);
        chk("reg_data", 32'({bus.cmd_reg, bus.cmd_data}), 32'(tbl[m_idx]));
        if (prev_hold) chk("hold_stable", 32'({bus.cmd_reg, bus.cmd_data}), 32'(prev_rd));
      end

      acc = bus.cmd_valid && bus.cmd_ready;
      if (bus.cmd_valid && !prev_valid && nack_cyc >= 0) begin
        gap = cyc - nack_cyc;
        n_gaps++;
        if (gap < min_gap) min_gap = gap;
        nack_cyc = -1;
      end
      if (bus.cmd_valid && !bus.cmd_ready && bus.cmd_reg == 8'h9C) hold_9c++;
      prev_hold  = bus.cmd_valid && !bus.cmd_ready;
      prev_rd    = {bus.cmd_reg, bus.cmd_data};
      prev_valid = bus.cmd_valid;
      if (acc) acc_log.push_back({bus.cmd_reg, bus.cmd_data});

      if (m_status != ST_RUN) begin
        if (rise) m_restart();
      end else if (m_out) begin
        if (bus.cmd_done) begin
          m_out = 0;
          if (m_pend || rise) m_restart();
          else if (!bus.cmd_nack) begin
            if (m_idx == 11) m_status = ST_DONE;
            else begin m_idx++; m_retries = 0; m_valid_at = cyc + 1; end
          end else begin
            nack_cyc = cyc;
            if (m_retries == int'(MAXR)) m_status = ST_ERR;
            else begin m_retries++; m_valid_at = cyc + 1 + int'(GAP); end
          end
        end else if (rise) m_pend = 1;
      end else if (acc) begin
        m_out = 1; m_pend = rise;
      end else if (rise) m_restart();
    end
  end

  // ---------------- helpers ----------------
  function automatic int count_of(input logic [15:0] v);
    int n = 0;
    foreach (acc_log[i]) if (acc_log[i] == v) n++;
    return n;
  endfunction

  task automatic wait_valid(input int budget);
    int n = 0;
    do begin @(negedge clk); #1; n++; end while (!bus.cmd_valid && n < budget);
    chk("valid_reached", 32'(bus.cmd_valid), 32'd1);
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(cfg_done || cfg_error) && n < budget) begin @(negedge clk); #1; n++; end
    chk("end_reached", 32'(cfg_done || cfg_error), 32'd1);
  endtask

  task automatic wait_log(input int sz, input int budget);
    int n = 0;
    while (acc_log.size() < sz && n < budget) begin @(negedge clk); #1; n++; end
    chk("log_reached", 32'(acc_log.size() >= sz), 32'd1);
  endtask

  task automatic hpd_restart();
    int n = 0;
    @(posedge clk); #1 hpd_event = 1'b1;
    repeat (3) @(posedge clk);
    #1 hpd_event = 1'b0;
    while (!busy && n < 20) begin @(negedge clk); #1; n++; end
    chk("restart_busy",  32'(busy),      32'd1);
    chk("restart_done",  32'(cfg_done),  32'd0);
    chk("restart_error", 32'(cfg_error), 32'd0);
    acc_log.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int rel;
    rst = 1'b1;
    hpd_event = 1'b0;
    foreach (nack_left[i]) begin nack_left[i] = 0; nack_always[i] = 0; end

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_valid_lit", 32'(bus.cmd_valid), 32'd0);
    chk("reset_busy_lit",  32'(busy),          32'd1);

    // clean run
    @(posedge clk); #1 rst = 1'b0; rel = cyc;
    wait_valid(100);
    chk("first_valid_latency", 32'(cyc - rel), 32'd16);
    wait_end(600);
    chk("clean_done",  32'(cfg_done), 32'd1);
    chk("clean_busy",  32'(busy),     32'd0);
    chk("clean_count", 32'(acc_log.size()), 32'd12);
    for (int i = 0; i < 12 && i < acc_log.size(); i++) chk("clean_order", 32'(acc_log[i]), 32'(tbl[i]));

    // hot-plug in DONE replays the table
    hpd_restart();
    rel = cyc;
    wait_valid(100);
    chk("replay_first", 32'({bus.cmd_reg, bus.cmd_data}), 32'h4110);
    wait_end(600);
    chk("replay_done",  32'(cfg_done), 32'd1);
    chk("replay_count", 32'(acc_log.size()), 32'd12);

    // backpressure on entry 3
    bp_en = 1; hold_9c = 0;
    hpd_restart();
    wait_end(600);
    chk("bp_hold_cycles", 32'(hold_9c), 32'd5);
    chk("bp_one_accept",  32'(count_of(16'h9C30)), 32'd1);
    chk("bp_done",        32'(cfg_done), 32'd1);
    bp_en = 0;

    // NACK entry 5 twice, then ACK
    nack_left[5] = 2; n_gaps = 0; min_gap = 1000;
    hpd_restart();
    wait_end(800);
    chk("nack_a2_accepts", 32'(count_of(16'hA2A4)), 32'd3);
    chk("nack_gaps",       32'(n_gaps), 32'd2);
    chk("nack_gap_ge8",    32'(min_gap >= 8), 32'd1);
    chk("nack_done",       32'(cfg_done), 32'd1);
    chk("nack_count",      32'(acc_log.size()), 32'd14);

    // entry 0 always NACKed -> ERROR
    nack_always[0] = 1;
    hpd_restart();
    wait_end(800);
    chk("err_flag",    32'(cfg_error), 32'd1);
    chk("err_busy",    32'(busy),      32'd0);
    chk("err_accepts", 32'(count_of(16'h4110)), 32'd3);
    repeat (30) @(negedge clk);
    #1 chk("err_no_more", 32'(acc_log.size()), 32'd3);
    nack_always[0] = 0;

    // hot-plug during WAIT_ACK of entry 7
    done_lat = 8;
    hpd_restart();
    wait_log(8, 800);
    hpd_event = 1'b1;
    repeat (3) @(posedge clk);
    #1 hpd_event = 1'b0;
    wait_log(9, 400);
    if (acc_log.size() >= 9) begin
      chk("hpd7_entry7",  32'(acc_log[7]), 32'hE0D0);
      chk("hpd7_restart", 32'(acc_log[8]), 32'h4110);
    end
    chk("hpd7_no_f9", 32'(count_of(16'hF900)), 32'd0);
    done_lat = 2;
    wait_end(800);
    chk("hpd7_done",  32'(cfg_done), 32'd1);
    chk("hpd7_count", 32'(acc_log.size()), 32'd20);

    // async reset while VALID is high
    fixed_dly = 3;
    hpd_restart();
    wait_valid(100);
    #1 rst = 1'b1;
    #1;
    chk("areset_valid", 32'(bus.cmd_valid), 32'd0);
    chk("areset_busy",  32'(busy),          32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; rel = cyc;
    acc_log.delete();
    fixed_dly = -1;
    @(negedge clk) inject_done = 1;
    wait_valid(100);
    chk("areset_latency", 32'(cyc - rel), 32'd16);
    chk("areset_entry0",  32'({bus.cmd_reg, bus.cmd_data}), 32'h4110);
    wait_end(600);
    chk("areset_done",  32'(cfg_done), 32'd1);
    chk("areset_count", 32'(acc_log.size()), 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
